// File: rtl/fb_scanout_pkg.sv
// Shared types for the 320x240 3-bit framebuffer scanout: color index, RGB struct,
// palette lookup and linear framebuffer indexing.
package fb_scanout_pkg;

  localparam int unsigned FB_W      = 320;
  localparam int unsigned FB_H      = 240;
  localparam int unsigned FB_PIXELS = FB_W * FB_H;

  localparam logic [9:0] VIS_W = 10'd640;
  localparam logic [9:0] VIS_H = 10'd480;

  typedef logic [2:0]  color_idx_t;
  typedef logic [16:0] fb_index_t;
  typedef logic [17:0] fb_addr_t;

  localparam color_idx_t SKY_COLOR  = 3'd1;
  localparam fb_index_t  LAST_INDEX = 17'(FB_PIXELS - 1);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  function automatic rgb24_t palette_lookup(input color_idx_t idx);
    rgb24_t c;
    case (idx)
      3'd0:    c = rgb24_t'(24'h000000);
      3'd1:    c = rgb24_t'(24'h87CEEB);
      3'd2:    c = rgb24_t'(24'h228B22);
      3'd3:    c = rgb24_t'(24'h8B5A2B);
      3'd4:    c = rgb24_t'(24'h808080);
      3'd5:    c = rgb24_t'(24'hEED9A0);
      3'd6:    c = rgb24_t'(24'h1E64C8);
      3'd7:    c = rgb24_t'(24'hFFFFFF);
      default: c = rgb24_t'(24'h000000);
    endcase
    return c;
  endfunction

  // Callers pass the raster coordinates already halved (2x pixel doubling).
  function automatic fb_index_t fb_index(input logic [8:0] x_half, input logic [8:0] y_half);
    fb_index_t row;
    row = {8'd0, y_half};
    return (row * 17'(FB_W)) + {8'd0, x_half};
  endfunction

endpackage

// File: rtl/fb_scanout_palette.sv
// Combinational 3-bit color index to 24-bit RGB map; shared by scanout and overlays.
module fb_palette
  import fb_scanout_pkg::*;
(
  input  logic [2:0] idx_i,
  output rgb24_t     rgb_o
);

  assign rgb_o = palette_lookup(idx_i);

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: raster-locked front-buffer read, palette map and buffer swap FSM.
// Optional FB_CLEAR_ON_SWAP_EN fills the new back buffer with SKY_COLOR before acking.
module fb_scanout
  import fb_scanout_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        pixel_en,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        render_done,
  output logic        render_ack,
  output logic        back_sel,
  output logic [17:0] rd_addr,
  input  logic [2:0]  rd_data,
  output logic        clr_we,
  output logic [17:0] clr_addr,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue
);

  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_PENDING = 3'd2;
  localparam logic [2:0] ST_ACK     = 3'd3;
`ifdef FB_CLEAR_ON_SWAP_EN
  localparam logic [2:0] ST_CLEAR   = 3'd4;
  localparam logic [2:0] ST_SWAPPED = ST_CLEAR;
`else
  localparam logic [2:0] ST_SWAPPED = ST_ACK;
`endif

  logic [2:0] state_q, state_d;
  logic       pending_q, pending_d;
  logic       back_sel_q, back_sel_d;
  logic       ack_q;
  logic       vblank_start_s;

  fb_addr_t   rd_addr_q, rd_addr_d;
  logic       vis_q, vis_d;
  logic       pix_q;
  rgb24_t     rgb_q, rgb_d;
  rgb24_t     pal_rgb_s;

`ifdef FB_CLEAR_ON_SWAP_EN
  fb_index_t  ctr_q, ctr_d;
  logic       clr_we_q;
  fb_addr_t   clr_addr_q;
`endif

  assign vblank_start_s = pixel_en && (DrawY == VIS_H) && (DrawX == 10'd0);

  fb_palette u_palette (
    .idx_i (rd_data),
    .rgb_o (pal_rgb_s)
  );

  // Swap FSM next state; a done in the swap cycle itself stays pending for next frame.
  always_comb begin
    state_d    = state_q;
    back_sel_d = back_sel_q;
    pending_d  = pending_q | render_done;
`ifdef FB_CLEAR_ON_SWAP_EN
    ctr_d      = ctr_q;
`endif
    case (state_q)
      ST_INIT: begin
        state_d = ST_SWAPPED;
`ifdef FB_CLEAR_ON_SWAP_EN
        ctr_d   = 17'd0;
`endif
      end
      ST_IDLE: begin
        if (pending_q || render_done) begin
          state_d = ST_PENDING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (vblank_start_s) begin
          back_sel_d = ~back_sel_q;
          pending_d  = render_done;
          state_d    = ST_SWAPPED;
`ifdef FB_CLEAR_ON_SWAP_EN
          ctr_d      = 17'd0;
`endif
        end else begin
          state_d = ST_PENDING;
        end
      end
`ifdef FB_CLEAR_ON_SWAP_EN
      ST_CLEAR: begin
        if (ctr_q == LAST_INDEX) begin
          state_d = ST_ACK;
        end else begin
          ctr_d   = ctr_q + 17'd1;
          state_d = ST_CLEAR;
        end
      end
`endif
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Swap FSM state and its registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_INIT;
      pending_q  <= 1'b0;
      back_sel_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      back_sel_q <= back_sel_d;
      ack_q      <= (state_d == ST_ACK);
    end
  end

`ifdef FB_CLEAR_ON_SWAP_EN
  // Clear engine: one back-buffer write per Clk while in CLEAR.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ctr_q      <= 17'd0;
      clr_we_q   <= 1'b0;
      clr_addr_q <= 18'd0;
    end else begin
      ctr_q      <= ctr_d;
      clr_we_q   <= (state_d == ST_CLEAR);
      clr_addr_q <= (state_d == ST_CLEAR) ? {back_sel_d, ctr_d} : clr_addr_q;
    end
  end

  assign clr_we   = clr_we_q;
  assign clr_addr = clr_addr_q;
`else
  assign clr_we   = 1'b0;
  assign clr_addr = 18'd0;
`endif

  // Read pipeline: address at the pixel_en cycle, colour one Clk later.
  always_comb begin
    rd_addr_d = rd_addr_q;
    vis_d     = vis_q;
    rgb_d     = rgb_q;
    if (pixel_en) begin
      rd_addr_d = {~back_sel_q, fb_index(DrawX[9:1], DrawY[9:1])};
      vis_d     = (DrawX < VIS_W) && (DrawY < VIS_H);
    end else begin
      rd_addr_d = rd_addr_q;
      vis_d     = vis_q;
    end
    if (pix_q) begin
      rgb_d = vis_q ? pal_rgb_s : rgb24_t'(24'h000000);
    end else begin
      rgb_d = rgb_q;
    end
  end

  // Read pipeline registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_addr_q <= 18'd0;
      vis_q     <= 1'b0;
      pix_q     <= 1'b0;
      rgb_q     <= rgb24_t'(24'h000000);
    end else begin
      rd_addr_q <= rd_addr_d;
      vis_q     <= vis_d;
      pix_q     <= pixel_en;
      rgb_q     <= rgb_d;
    end
  end

  assign render_ack = ack_q;
  assign back_sel   = back_sel_q;
  assign rd_addr    = rd_addr_q;
  assign Red        = rgb_q.r;
  assign Green      = rgb_q.g;
  assign Blue       = rgb_q.b;

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: pixel reads/colours and swap/ack handshakes.
module tb_fb_scanout;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        pixel_en = 1'b0;
  logic [9:0]  DrawX = 10'd0;
  logic [9:0]  DrawY = 10'd0;
  logic        render_done = 1'b0;
  logic [2:0]  rd_data = 3'd0;
  logic        render_ack, back_sel, clr_we;
  logic [17:0] rd_addr, clr_addr;
  logic [7:0]  Red, Green, Blue;

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] exp_addr_q[$];
  logic [23:0] exp_rgb_q[$];
  logic        exp_ack_q[$];
  logic        pe_d1 = 1'b0;
  logic        pe_d2 = 1'b0;

`ifdef FB_CLEAR_ON_SWAP_EN
  localparam int ACK_BOUND = 76810;
`else
  localparam int ACK_BOUND = 3;
`endif

  always #5 Clk = ~Clk;

  fb_scanout dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .pixel_en    (pixel_en),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .render_done (render_done),
    .render_ack  (render_ack),
    .back_sel    (back_sel),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .clr_we      (clr_we),
    .clr_addr    (clr_addr),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Track which cycles carry a pixel result.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pe_d1 <= 1'b0;
      pe_d2 <= 1'b0;
    end else begin
      pe_d1 <= pixel_en;
      pe_d2 <= pe_d1;
    end
  end

  // Monitor: pop and compare whenever the DUT presents an address, colour or ack.
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (pe_d1) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          $display("FAIL rd_addr_unexpected: got %0h with nothing expected", rd_addr);
        end else check("rd_addr", rd_addr, exp_addr_q.pop_front());
      end
      if (pe_d2) begin
        if (exp_rgb_q.size() == 0) begin
          n_checks++;
          $display("FAIL rgb_unexpected: got %0h with nothing expected", {Red, Green, Blue});
        end else check("rgb", {Red, Green, Blue}, exp_rgb_q.pop_front());
      end
      if (render_ack) begin
        if (exp_ack_q.size() == 0) begin
          n_checks++;
          $display("FAIL ack_unexpected: render_ack with no swap expected, back_sel=%0d", back_sel);
        end else check("ack_back_sel", back_sel, exp_ack_q.pop_front());
      end
    end
  end

  // Issue one pixel_en at a negedge; returns at the negedge right after the sampling edge.
  task automatic pix(input int x, input int y, input logic [2:0] rd, input logic done,
                     input logic [17:0] ea, input logic [23:0] ergb);
    exp_addr_q.push_back(ea);
    exp_rgb_q.push_back(ergb);
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    pixel_en    = 1'b1;
    render_done = done;
    @(posedge Clk);
    @(negedge Clk);
    pixel_en    = 1'b0;
    render_done = 1'b0;
    rd_data     = rd;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Called at the negedge just after the swap edge.
  task automatic after_swap(input logic exp_bs);
`ifdef FB_CLEAR_ON_SWAP_EN
    int n;
    logic [17:0] last;
    n = 0;
    last = 18'd0;
`endif
    check("swap_back_sel", back_sel, exp_bs);
`ifdef FB_CLEAR_ON_SWAP_EN
    check("clr_we_start", clr_we, 1'b1);
    check("clr_addr_start", clr_addr, {exp_bs, 17'd0});
    while (clr_we && n < 80000) begin
      last = clr_addr;
      n++;
      @(negedge Clk);
    end
    check("clr_len", n, 76800);
    check("clr_addr_last", last, {exp_bs, 17'd76799});
`endif
    check("ack_after_swap", render_ack, 1'b1);
  endtask

  initial begin
    int  i;
    logic got;
    idle(3);
    check("rst_back_sel", back_sel, 1'b0);
    check("rst_ack", render_ack, 1'b0);
    check("rst_rd_addr", rd_addr, 18'd0);
    check("rst_clr_we", clr_we, 1'b0);
    check("rst_clr_addr", clr_addr, 18'd0);
    check("rst_rgb", {Red, Green, Blue}, 24'h0);

    // First release of the renderer comes without any render_done.
    exp_ack_q.push_back(1'b0);
    Reset_n = 1'b1;
    got = 1'b0;
    for (i = 0; i < ACK_BOUND && !got; i++) begin
      @(negedge Clk);
      if (render_ack) got = 1'b1;
    end
    check("reset_ack_seen", got, 1'b1);
    idle(3);
    check("reset_back_sel", back_sel, 1'b0);

    // Frame 1: back_sel=0, front=1.
    pix(5,   7,   3'd6, 1'b0, 18'h203C2, 24'h1E64C8);
    pix(700, 10,  3'd5, 1'b0, 18'h2079E, 24'h000000);
    pix(639, 0,   3'd2, 1'b0, 18'h2013F, 24'h228B22);
    pix(640, 479, 3'd7, 1'b0, 18'h32C00, 24'h000000);
    pix(0,   0,   3'd1, 1'b0, 18'h20000, 24'h87CEEB);
    idle(3);
    rd_data = 3'd7;
    idle(3);
    check("hold_rgb", {Red, Green, Blue}, 24'h87CEEB);
    check("hold_rd_addr", rd_addr, 18'h20000);

    pix(8, 100, 3'd4, 1'b1, 18'h23E84, 24'h808080);
    check("no_swap_y100", back_sel, 1'b0);
    pix(0, 479, 3'd7, 1'b0, 18'h32AC0, 24'hFFFFFF);
    check("no_swap_y479", back_sel, 1'b0);
    pix(1, 480, 3'd0, 1'b0, 18'h32C00, 24'h000000);
    check("no_swap_x1", back_sel, 1'b0);
    exp_ack_q.push_back(1'b1);
    pix(0, 480, 3'd0, 1'b0, 18'h32C00, 24'h000000);
    after_swap(1'b1);
    idle(4);

    // Frame 2: back_sel=1, front=0; second done is absorbed.
    pix(10, 20,  3'd3, 1'b0, 18'h00C85, 24'h8B5A2B);
    pix(2,  2,   3'd4, 1'b0, 18'h00141, 24'h808080);
    pix(4,  0,   3'd0, 1'b0, 18'h00002, 24'h000000);
    pix(0,  100, 3'd1, 1'b1, 18'h03E80, 24'h87CEEB);
    pix(2,  200, 3'd2, 1'b1, 18'h07D01, 24'h228B22);
    check("no_swap_frame2", back_sel, 1'b1);
    exp_ack_q.push_back(1'b0);
    pix(0, 480, 3'd0, 1'b0, 18'h12C00, 24'h000000);
    after_swap(1'b0);
    idle(4);

    // Frame 3: done on the vblank pixel itself swaps only a frame later.
    pix(0, 480, 3'd0, 1'b1, 18'h32C00, 24'h000000);
    check("done_on_vblank_no_swap", back_sel, 1'b0);
    idle(4);
    exp_ack_q.push_back(1'b1);
    pix(0, 480, 3'd0, 1'b0, 18'h32C00, 24'h000000);
    after_swap(1'b1);
    idle(4);

    check("acks_all_seen", exp_ack_q.size(), 0);
    check("pixels_all_seen", exp_rgb_q.size(), 0);

`ifdef FB_CLEAR_ON_SWAP_EN
    // Reset in the middle of a clear aborts it immediately.
    pix(0, 100, 3'd1, 1'b1, 18'h03E80, 24'h87CEEB);
    pix(0, 480, 3'd0, 1'b0, 18'h12C00, 24'h000000);
    idle(1000);
    check("mid_clear_we", clr_we, 1'b1);
    Reset_n = 1'b0;
    #1;
    check("abort_clr_we", clr_we, 1'b0);
    check("abort_back_sel", back_sel, 1'b0);
    check("abort_ack", render_ack, 1'b0);
    exp_ack_q.delete();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
